mem_port_arbiter: RTL

//  Shares one single-ported unified instruction/data memory between the IF stage and the MEM stage.
//  - Fetch requests and LW/SW requests (driven by MemRead/MemWrite) are arbitrated here.
//  - Each granted access is sequenced through a fixed-latency memory.
//  - The arbiter returns per-port acks and drives the stall_if/stall_mem lines into the hazard

---
 rtl/mem_port_arbiter_if.sv | 85 ++++++++
 rtl/mem_port_arbiter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter_if
//
// Purpose:
//   Bundles the signals between the pipeline's two memory ports (IF fetch and
//   MEM load/store), the shared single-ported memory and the hazard unit
//   (stall lines). Clock and reset are not part of the bundle; they stay
//   plain ports on each module.
//
// Signal summary (direction as seen by the arbiter, modport "slave"):
//   if_req     in   fetch request, held with if_addr until if_ack
//   if_addr    in   fetch byte address
//   if_rdata   out  fetched instruction, valid while if_ack=1
//   if_ack     out  one-cycle fetch completion
//   dm_read    in   MemRead from the MEM stage
//   dm_write   in   MemWrite from the MEM stage
//   dm_addr    in   data byte address
//   dm_wdata   in   store data
//   dm_wstrb   in   store byte enables
//   dm_rdata   out  load data, valid while dm_ack=1
//   dm_ack     out  one-cycle data completion
//   mem_en     out  memory issue strobe, one cycle per access
//   mem_we     out  write qualifier for mem_en
//   mem_wstrb  out  byte enables to memory
//   mem_addr   out  memory byte address
//   mem_wdata  out  memory write data
//   mem_rdata  in   memory read data
//   stall_if   out  fetch port still waiting
//   stall_mem  out  data port still waiting
//
// Modports:
//   slave  - the arbiter
//   master - the environment (pipeline stages + memory model)
// ---------------------------------------------------------------------------
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32
);
    // Fetch port
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_ack;

    // Data port
    logic              dm_read;
    logic              dm_write;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic [3:0]        dm_wstrb;
    logic [DATA_W-1:0] dm_rdata;
    logic              dm_ack;

    // Memory side
    logic              mem_en;
    logic              mem_we;
    logic [3:0]        mem_wstrb;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    // Hazard unit
    logic              stall_if;
    logic              stall_mem;

    modport slave (
        input  if_req, if_addr,
        output if_rdata, if_ack,
        input  dm_read, dm_write, dm_addr, dm_wdata, dm_wstrb,
        output dm_rdata, dm_ack,
        output mem_en, mem_we, mem_wstrb, mem_addr, mem_wdata,
        input  mem_rdata,
        output stall_if, stall_mem
    );

    modport master (
        output if_req, if_addr,
        input  if_rdata, if_ack,
        output dm_read, dm_write, dm_addr, dm_wdata, dm_wstrb,
        input  dm_rdata, dm_ack,
        input  mem_en, mem_we, mem_wstrb, mem_addr, mem_wdata,
        output mem_rdata,
        input  stall_if, stall_mem
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Purpose:
//   Shares one single-ported, fixed-latency unified instruction/data memory
//   between the IF stage (fetch) and the MEM stage (loads/stores). One access
//   is in flight at a time. Each access goes IDLE (grant) -> ISSUE (mem_en
//   pulse) -> WAIT (count down the memory latency) -> completion, where the
//   owning port gets a one-cycle ack with read data passed straight through
//   from the memory. The stall lines tell the hazard logic to freeze a stage
//   until its access completes.
//
// Parameters:
//   ADDR_W   byte-address width presented to the memory
//   DATA_W   data word width
//   MEM_LAT  cycles from the mem_en cycle to valid mem_rdata (1..15)
//
// Ports:
//   clk    in  rising-edge clock
//   reset  in  asynchronous active-high reset
//   bus    slave modport of mem_port_arbiter_if (fetch port, data port,
//          memory side and stall lines)
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int ADDR_W  = 9,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2
) (
    input  logic                clk,
    input  logic                reset,
    mem_port_arbiter_if.slave   bus
);

    localparam int CNT_W = 4;
    // Value loaded in ISSUE; the completion cycle is the WAIT cycle where the
    // counter reads zero, i.e. exactly MEM_LAT cycles after the mem_en cycle.
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } owner_t;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    state_t             state_q,     state_d;
    logic [CNT_W-1:0]   cnt_q,       cnt_d;
    logic               last_dm_q,   last_dm_d;
    owner_t             owner_q,     owner_d;
    logic               mem_en_q,    mem_en_d;
    logic               mem_we_q,    mem_we_d;
    logic [3:0]         mem_wstrb_q, mem_wstrb_d;
    logic [ADDR_W-1:0]  mem_addr_q,  mem_addr_d;
    logic [DATA_W-1:0]  mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0]  if_rdata_q,  if_rdata_d;
    logic [DATA_W-1:0]  dm_rdata_q,  dm_rdata_d;

    // -----------------------------------------------------------------------
    // Request decode and arbitration
    // -----------------------------------------------------------------------
    logic dm_req;
    logic done;
    logic grant_dm;
    logic grant_if;
    logic if_ack_c;
    logic dm_ack_c;

    always_comb begin
        dm_req   = bus.dm_read | bus.dm_write;
        done     = (state_q == WAIT) && (cnt_q == '0);

        // DM has priority on a tie unless it owned the previous access, so
        // neither port can be starved while both keep requesting.
        grant_dm = dm_req && (!bus.if_req || !last_dm_q);
        grant_if = bus.if_req && !grant_dm;

        // An owner that withdrew its request (e.g. fetch flushed by a taken
        // branch) still lets the access finish, but gets no ack.
        if_ack_c = done && (owner_q == OWN_IF) && bus.if_req;
        dm_ack_c = done && (owner_q == OWN_DM) && dm_req;
    end

    // -----------------------------------------------------------------------
    // Next-state and datapath logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        last_dm_d   = last_dm_q;
        owner_d     = owner_q;
        mem_en_d    = 1'b0;
        mem_we_d    = mem_we_q;
        mem_wstrb_d = mem_wstrb_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;

        unique case (state_q)
            IDLE: begin
                if (grant_dm) begin
                    state_d     = ISSUE;
                    mem_en_d    = 1'b1;
                    owner_d     = OWN_DM;
                    mem_addr_d  = bus.dm_addr;
                    // MemRead and MemWrite together is treated as a store.
                    mem_we_d    = bus.dm_write;
                    mem_wstrb_d = bus.dm_write ? bus.dm_wstrb : 4'b0000;
                    mem_wdata_d = bus.dm_wdata;
                end else if (grant_if) begin
                    state_d     = ISSUE;
                    mem_en_d    = 1'b1;
                    owner_d     = OWN_IF;
                    mem_addr_d  = bus.if_addr;
                    mem_we_d    = 1'b0;
                    mem_wstrb_d = 4'b0000;
                    mem_wdata_d = '0;
                end
            end

            ISSUE: begin
                // With MEM_LAT=1 the load value is zero, so the very next
                // WAIT cycle is already the completion cycle.
                cnt_d   = CNT_LOAD;
                state_d = WAIT;
            end

            WAIT: begin
                if (cnt_q == '0) begin
                    // Completion: never grant here, always pass through IDLE.
                    state_d   = IDLE;
                    last_dm_d = (owner_q == OWN_DM);
                    if (if_ack_c) begin
                        if_rdata_d = bus.mem_rdata;
                    end
                    if (dm_ack_c) begin
                        dm_rdata_d = bus.mem_rdata;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            last_dm_q   <= 1'b0;
            owner_q     <= OWN_IF;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_wstrb_q <= 4'b0000;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            last_dm_q   <= last_dm_d;
            owner_q     <= owner_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_wstrb_q <= mem_wstrb_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    // mem_en_q is set only on the grant edge, so it is high exactly in ISSUE.
    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_wstrb = mem_wstrb_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;

    assign bus.if_ack    = if_ack_c;
    assign bus.dm_ack    = dm_ack_c;

    // Owner sees memory data the same cycle it arrives; otherwise each port
    // shows the last value it was handed.
    assign bus.if_rdata  = if_ack_c ? bus.mem_rdata : if_rdata_q;
    assign bus.dm_rdata  = dm_ack_c ? bus.mem_rdata : dm_rdata_q;

    // Combinational so a stage is released in the same cycle as its ack.
    assign bus.stall_if  = bus.if_req & ~if_ack_c;
    assign bus.stall_mem = dm_req & ~dm_ack_c;

endmodule
